// File: rtl/fifo_axi_pkg.sv
// rtl/fifo_axi_pkg.sv - AXI4 constants and writer FSM state encoding shared by the FIFO-to-AXI writer
package fifo_axi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_RESP = 2'd3
    } wr_state_e;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [1:0] RESP_OKAY  = 2'b00;

    // AxSIZE is log2 of the bytes per beat
    function automatic logic [2:0] axsize_enc(input int unsigned beat_bytes);
        logic [2:0] enc;
        enc = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if ((32'd1 << i) == beat_bytes) begin
                enc = 3'(i);
            end
        end
        return enc;
    endfunction

endpackage

// File: rtl/fifo_axi_writer_if.sv
// rtl/fifo_axi_writer_if.sv - AXI4 write-only bus (AW, W, B channels) between writer and DDR slave
interface fifo_axi_writer_if #(
    parameter int unsigned DATA_WIDTH = 128,
    parameter int unsigned ADDR_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   m_axi_awaddr;
    logic [7:0]              m_axi_awlen;
    logic [2:0]              m_axi_awsize;
    logic [1:0]              m_axi_awburst;
    logic                    m_axi_awvalid;
    logic                    m_axi_awready;

    logic [DATA_WIDTH-1:0]   m_axi_wdata;
    logic [DATA_WIDTH/8-1:0] m_axi_wstrb;
    logic                    m_axi_wlast;
    logic                    m_axi_wvalid;
    logic                    m_axi_wready;

    logic [1:0]              m_axi_bresp;
    logic                    m_axi_bvalid;
    logic                    m_axi_bready;

    modport master (
        output m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst, m_axi_awvalid,
        input  m_axi_awready,
        output m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wvalid,
        input  m_axi_wready,
        input  m_axi_bresp, m_axi_bvalid,
        output m_axi_bready
    );

    modport slave (
        input  m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst, m_axi_awvalid,
        output m_axi_awready,
        input  m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wvalid,
        output m_axi_wready,
        output m_axi_bresp, m_axi_bvalid,
        input  m_axi_bready
    );
endinterface

// File: rtl/word_skid_reg.sv
// rtl/word_skid_reg.sv - One-word holding register between the FIFO read port and the AXI W channel
module word_skid_reg #(
    parameter int unsigned DATA_WIDTH = 128
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fetch,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  ready,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  valid,
    output logic                  free_next
);
    logic                  pending;
    logic [DATA_WIDTH-1:0] data_q;

    // A read issued last cycle lands now; the caller only fetches when the slot will be empty
    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= 1'b0;
            valid   <= 1'b0;
            data_q  <= '0;
        end else begin
            pending <= fetch;
            if (pending) begin
                data_q <= din;
                valid  <= 1'b1;
            end else if (valid && ready) begin
                valid <= 1'b0;
            end
        end
    end

    assign free_next = !pending && (!valid || ready);
    assign dout      = valid ? data_q : '0;

endmodule

// File: rtl/fifo_axi_writer.sv
// rtl/fifo_axi_writer.sv - Drains a FIFO into fixed-length AXI4 INCR write bursts over a wrapping DDR window
module fifo_axi_writer
    import fifo_axi_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 128,
    parameter int unsigned ADDR_WIDTH   = 32,
    parameter int unsigned BURST_LEN    = 16,
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
    parameter logic [31:0] REGION_BYTES = 32'h0001_0000,
    parameter int unsigned CNT_WIDTH    = 11
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    input  logic [CNT_WIDTH-1:0]  fifo_count,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    fifo_axi_writer_if.master     axi,
    output logic                  busy,
    output logic [15:0]           burst_count,
    output logic                  wr_err
);
    localparam logic [ADDR_WIDTH-1:0] BASE        = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [ADDR_WIDTH-1:0] REGION_END  = ADDR_WIDTH'(BASE_ADDR + REGION_BYTES);
    localparam logic [ADDR_WIDTH-1:0] BURST_BYTES = ADDR_WIDTH'(BURST_LEN * (DATA_WIDTH / 8));
    localparam logic [8:0]            BEATS       = 9'(BURST_LEN);
    localparam logic [8:0]            LAST_BEAT   = 9'(BURST_LEN - 1);

    wr_state_e             state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_inc;
    logic [8:0]            fetch_left_q;
    logic [8:0]            beat_q;
    logic                  last_done_q;

    logic                  skid_valid, skid_free;
    logic [DATA_WIDTH-1:0] skid_data;

    logic start, in_addr, fetching, aw_hs, w_hs, wlast_hs, b_hs;

    assign start    = (state_q == ST_IDLE) && enable && (32'(fifo_count) >= BURST_LEN);
    assign fetching = (state_q == ST_ADDR || state_q == ST_DATA) && (fetch_left_q != 9'd0);
    assign aw_hs    = axi.m_axi_awvalid && axi.m_axi_awready;
    assign w_hs     = axi.m_axi_wvalid && axi.m_axi_wready;
    assign wlast_hs = w_hs && axi.m_axi_wlast;
    assign b_hs     = axi.m_axi_bvalid && axi.m_axi_bready;
    assign addr_inc = addr_q + BURST_BYTES;

    assign fifo_rd_en = fetching && !fifo_empty && skid_free;

    word_skid_reg #(.DATA_WIDTH(DATA_WIDTH)) u_skid (
        .clk       (clk),
        .rst       (rst),
        .fetch     (fifo_rd_en),
        .din       (fifo_dout),
        .ready     (axi.m_axi_wready),
        .dout      (skid_data),
        .valid     (skid_valid),
        .free_next (skid_free)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // W beats may complete before AWREADY, so ADDR can skip straight to RESP
    always_comb begin
        state_d           = state_q;
        in_addr           = 1'b0;
        axi.m_axi_bready  = 1'b0;
        busy              = 1'b1;
        unique case (state_q)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) state_d = ST_ADDR;
            end
            ST_ADDR: begin
                in_addr = 1'b1;
                if (aw_hs) state_d = (last_done_q || wlast_hs) ? ST_RESP : ST_DATA;
            end
            ST_DATA: begin
                if (wlast_hs) state_d = ST_RESP;
            end
            ST_RESP: begin
                axi.m_axi_bready = 1'b1;
                if (axi.m_axi_bvalid) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign axi.m_axi_awvalid = in_addr;
    assign axi.m_axi_awaddr  = in_addr ? addr_q : '0;
    assign axi.m_axi_awlen   = in_addr ? 8'(BURST_LEN - 1) : 8'd0;
    assign axi.m_axi_awsize  = in_addr ? axsize_enc(DATA_WIDTH / 8) : 3'd0;
    assign axi.m_axi_awburst = in_addr ? BURST_INCR : 2'b00;

    assign axi.m_axi_wvalid  = skid_valid;
    assign axi.m_axi_wdata   = skid_data;
    assign axi.m_axi_wstrb   = {(DATA_WIDTH / 8){skid_valid}};
    assign axi.m_axi_wlast   = skid_valid && (beat_q == LAST_BEAT);

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q       <= BASE;
            fetch_left_q <= 9'd0;
            beat_q       <= 9'd0;
            last_done_q  <= 1'b0;
            burst_count  <= 16'd0;
            wr_err       <= 1'b0;
        end else begin
            if (start) begin
                fetch_left_q <= BEATS;
                beat_q       <= 9'd0;
                last_done_q  <= 1'b0;
            end else begin
                if (fifo_rd_en) fetch_left_q <= fetch_left_q - 9'd1;
                if (w_hs)       beat_q       <= beat_q + 9'd1;
                if (wlast_hs)   last_done_q  <= 1'b1;
            end
            if (b_hs) begin
                burst_count <= burst_count + 16'd1;
                if (axi.m_axi_bresp != RESP_OKAY) wr_err <= 1'b1;
                addr_q <= (addr_inc == REGION_END) ? BASE : addr_inc;
            end
        end
    end

endmodule
